// File: rtl/aud_ctrl_fsm.sv
// Record/play control FSM for the WM8731 audio path: divides SRAM into equal slots, tracks each
// slot's recorded length, and issues one-cycle command pulses to codec init, recorder and DSP.
module aud_ctrl_fsm #(
    parameter int ADDR_W     = 20,
    parameter int N_SLOTS    = 4,
    parameter int INIT_PULSE = 2,
    localparam int SW        = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_key_rec,
    input  logic              i_key_play,
    input  logic              i_key_stop,
    input  logic [SW-1:0]     i_slot,
    input  logic              i_loop,
    input  logic              i_i2c_done,
    input  logic [ADDR_W-1:0] i_rec_addr,
    input  logic [ADDR_W-1:0] i_play_addr,
    output logic              o_i2c_start,
    output logic              o_rec_start,
    output logic              o_rec_pause,
    output logic              o_rec_stop,
    output logic              o_dsp_start,
    output logic              o_dsp_pause,
    output logic              o_dsp_stop,
    output logic              o_sram_wr,
    output logic [ADDR_W-1:0] o_slot_base,
    output logic [ADDR_W-1:0] o_slot_end,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        RECD  = 3'd2,
        RECDP = 3'd3,
        PLAY  = 3'd4,
        PLAYP = 3'd5,
        WREL  = 3'd6
    } state_t;

    localparam int LOG_N  = $clog2(N_SLOTS);
    localparam int SLOT_W = ADDR_W - LOG_N;
    localparam int NE     = 2 ** SW;
    localparam int CW     = $clog2(INIT_PULSE + 2);
    localparam logic [ADDR_W:0] SLOT_LEN = (ADDR_W + 1)'(1) << SLOT_W;

    localparam int C_REC_START = 0;
    localparam int C_REC_PAUSE = 1;
    localparam int C_REC_STOP  = 2;
    localparam int C_DSP_START = 3;
    localparam int C_DSP_PAUSE = 4;
    localparam int C_DSP_STOP  = 5;

    // Slot ends are held one bit wider so a full last slot is distinguishable from its empty base.
    function automatic logic [ADDR_W:0] base_of(input logic [SW-1:0] s);
        logic [ADDR_W:0] b;
        b = '0;
        if (N_SLOTS > 1) b = (ADDR_W + 1)'(s) << SLOT_W;
        return b;
    endfunction

    state_t          state_q, state_d;
    state_t          nxt_q, nxt_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [ADDR_W:0] slot_end_q [NE];
    logic            restart_q, restart_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            i2c_start_q, i2c_start_d;
    logic [5:0]      cmd_q, cmd_d;
    logic            sram_wr_q, sram_wr_d;

    logic            end_we;
    logic [SW-1:0]   end_idx;
    logic [ADDR_W:0] end_val;

    logic [ADDR_W:0] cur_base, cur_end, sel_base, sel_end, rec_ext, play_ext;
    logic            rec_k, play_k, stop_k;

    assign cur_base = base_of(slot_q);
    assign cur_end  = slot_end_q[slot_q];
    assign sel_base = base_of(i_slot);
    assign sel_end  = slot_end_q[i_slot];
    assign rec_ext  = {1'b0, i_rec_addr};
    assign play_ext = {1'b0, i_play_addr};

    // stop > rec > play when several keys are down together
    assign stop_k = i_key_stop;
    assign rec_k  = i_key_rec & ~i_key_stop;
    assign play_k = i_key_play & ~i_key_stop & ~i_key_rec;

    always_comb begin
        state_d     = state_q;
        nxt_d       = nxt_q;
        slot_d      = slot_q;
        restart_d   = 1'b0;
        cnt_d       = cnt_q;
        i2c_start_d = 1'b0;
        cmd_d       = '0;
        end_we      = 1'b0;
        end_idx     = slot_q;
        end_val     = cur_end;

        unique case (state_q)
            INIT: begin
                if (cnt_q != CW'(INIT_PULSE)) cnt_d = cnt_q + 1'b1;
                i2c_start_d = (cnt_d < CW'(INIT_PULSE));
                if (i_i2c_done) begin
                    state_d     = IDLE;
                    i2c_start_d = 1'b0;
                end
            end
            IDLE: begin
                slot_d = i_slot;
                if (rec_k) begin
                    end_we  = 1'b1;
                    end_idx = i_slot;
                    end_val = sel_base;
                    nxt_d   = RECD;
                    state_d = WREL;
                end else if (play_k && (sel_end != sel_base)) begin
                    nxt_d   = PLAY;
                    state_d = WREL;
                end
            end
            RECD: begin
                end_we  = 1'b1;
                end_val = rec_ext + 1'b1;
                if (rec_ext >= cur_base + SLOT_LEN - 1'b1) begin
                    end_val           = cur_base + SLOT_LEN;
                    cmd_d[C_REC_STOP] = 1'b1;
                    state_d           = IDLE;
                end else if (stop_k) begin
                    cmd_d[C_REC_STOP] = 1'b1;
                    state_d           = IDLE;
                end else if (rec_k) begin
                    nxt_d   = RECDP;
                    state_d = WREL;
                end
            end
            RECDP: begin
                if (stop_k) begin
                    cmd_d[C_REC_STOP] = 1'b1;
                    state_d           = IDLE;
                end else if (rec_k) begin
                    nxt_d   = RECD;
                    state_d = WREL;
                end
            end
            PLAY: begin
                // restart_q marks the cycle after a loop-wrap stop, where the DSP is restarted
                if (restart_q) begin
                    if (stop_k) state_d = IDLE;
                    else cmd_d[C_DSP_START] = 1'b1;
                end else if (stop_k || (play_ext >= cur_end)) begin
                    cmd_d[C_DSP_STOP] = 1'b1;
                    if (!stop_k && i_loop) restart_d = 1'b1;
                    else state_d = IDLE;
                end else if (play_k) begin
                    nxt_d   = PLAYP;
                    state_d = WREL;
                end
            end
            PLAYP: begin
                if (stop_k) begin
                    cmd_d[C_DSP_STOP] = 1'b1;
                    state_d           = IDLE;
                end else if (play_k) begin
                    nxt_d   = PLAY;
                    state_d = WREL;
                end
            end
            WREL: begin
                if (stop_k) begin
                    state_d = IDLE;
                end else if (!i_key_rec && !i_key_play) begin
                    state_d = nxt_q;
                    unique case (nxt_q)
                        RECD:    cmd_d[C_REC_START] = 1'b1;
                        RECDP:   cmd_d[C_REC_PAUSE] = 1'b1;
                        PLAY:    cmd_d[C_DSP_START] = 1'b1;
                        PLAYP:   cmd_d[C_DSP_PAUSE] = 1'b1;
                        default: state_d = IDLE;
                    endcase
                end
            end
            default: state_d = INIT;
        endcase

        sram_wr_d = (state_d == RECD) || (state_d == RECDP);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= INIT;
            nxt_q       <= IDLE;
            slot_q      <= '0;
            restart_q   <= 1'b0;
            cnt_q       <= '0;
            i2c_start_q <= 1'b1;
            cmd_q       <= '0;
            sram_wr_q   <= 1'b0;
            for (int k = 0; k < NE; k++) slot_end_q[k] <= base_of(SW'(k));
        end else begin
            state_q     <= state_d;
            nxt_q       <= nxt_d;
            slot_q      <= slot_d;
            restart_q   <= restart_d;
            cnt_q       <= cnt_d;
            i2c_start_q <= i2c_start_d;
            cmd_q       <= cmd_d;
            sram_wr_q   <= sram_wr_d;
            if (end_we) slot_end_q[end_idx] <= end_val;
        end
    end

    assign o_i2c_start = i2c_start_q;
    assign o_rec_start = cmd_q[C_REC_START];
    assign o_rec_pause = cmd_q[C_REC_PAUSE];
    assign o_rec_stop  = cmd_q[C_REC_STOP];
    assign o_dsp_start = cmd_q[C_DSP_START];
    assign o_dsp_pause = cmd_q[C_DSP_PAUSE];
    assign o_dsp_stop  = cmd_q[C_DSP_STOP];
    assign o_sram_wr   = sram_wr_q;
    assign o_slot_base = cur_base[ADDR_W-1:0];
    assign o_slot_end  = cur_end[ADDR_W-1:0];
    assign o_state     = state_q;

endmodule

// File: tb/tb_aud_ctrl_fsm.sv
// Bench for aud_ctrl_fsm: directed scenarios plus a long randomized run, all checked against a
// slot/mode reference model evaluated on every rising edge.
module tb_aud_ctrl_fsm;

    localparam int     INIT_PULSE = 2;
    localparam longint LEN        = 64'd1 << 18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_rec = 1'b0, key_play = 1'b0, key_stop = 1'b0;
    logic [1:0]  slot = 2'd0;
    logic        loop_en = 1'b0, i2c_done = 1'b0;
    logic [19:0] rec_addr = '0, play_addr = '0;

    logic        i2c_start, rec_start, rec_pause, rec_stop, dsp_start, dsp_pause, dsp_stop, sram_wr;
    logic [19:0] slot_base, slot_end;
    logic [2:0]  state;
    logic [5:0]  cmd;

    int errors = 0;
    int checks = 0;

    aud_ctrl_fsm #(.ADDR_W(20), .N_SLOTS(4), .INIT_PULSE(INIT_PULSE)) dut (
        .i_clk(clk), .i_rst(rst), .i_key_rec(key_rec), .i_key_play(key_play),
        .i_key_stop(key_stop), .i_slot(slot), .i_loop(loop_en), .i_i2c_done(i2c_done),
        .i_rec_addr(rec_addr), .i_play_addr(play_addr), .o_i2c_start(i2c_start),
        .o_rec_start(rec_start), .o_rec_pause(rec_pause), .o_rec_stop(rec_stop),
        .o_dsp_start(dsp_start), .o_dsp_pause(dsp_pause), .o_dsp_stop(dsp_stop),
        .o_sram_wr(sram_wr), .o_slot_base(slot_base), .o_slot_end(slot_end), .o_state(state)
    );

    assign cmd = {dsp_stop, dsp_pause, dsp_start, rec_stop, rec_pause, rec_start};

    always #5 clk = ~clk;

    // Reference model: modes use the published o_state numbering; slot ends are unbounded integers.
    int         m_state, m_next, m_slot, m_cnt;
    bit         m_restart, m_i2c, m_wr;
    logic [5:0] m_cmd;
    longint     m_end [4];

    always @(posedge clk) begin : model
        longint base;
        m_cmd = '0;
        if (rst) begin
            m_state = 0; m_next = 1; m_slot = 0; m_cnt = 0; m_restart = 0; m_i2c = 1;
            for (int k = 0; k < 4; k++) m_end[k] = k * LEN;
        end else begin
            base = longint'(m_slot) * LEN;
            case (m_state)
                0: begin
                    m_cnt++;
                    m_i2c = (m_cnt < INIT_PULSE);
                    if (i2c_done) begin m_state = 1; m_i2c = 0; end
                end
                1: begin
                    m_slot = int'(slot);
                    base = longint'(m_slot) * LEN;
                    if (key_stop) ;
                    else if (key_rec) begin m_end[m_slot] = base; m_next = 2; m_state = 6; end
                    else if (key_play && m_end[m_slot] != base) begin m_next = 4; m_state = 6; end
                end
                2: begin
                    if (longint'(rec_addr) >= base + LEN - 1) begin
                        m_end[m_slot] = base + LEN; m_cmd[2] = 1; m_state = 1;
                    end else begin
                        m_end[m_slot] = longint'(rec_addr) + 1;
                        if (key_stop) begin m_cmd[2] = 1; m_state = 1; end
                        else if (key_rec) begin m_next = 3; m_state = 6; end
                    end
                end
                3: begin
                    if (key_stop) begin m_cmd[2] = 1; m_state = 1; end
                    else if (key_rec) begin m_next = 2; m_state = 6; end
                end
                4: begin
                    if (m_restart) begin
                        m_restart = 0;
                        if (key_stop) m_state = 1; else m_cmd[3] = 1;
                    end else if (key_stop || longint'(play_addr) >= m_end[m_slot]) begin
                        m_cmd[5] = 1;
                        if (!key_stop && loop_en) m_restart = 1; else m_state = 1;
                    end else if (key_play && !key_rec) begin
                        m_next = 5; m_state = 6;
                    end
                end
                5: begin
                    if (key_stop) begin m_cmd[5] = 1; m_state = 1; end
                    else if (key_play && !key_rec) begin m_next = 4; m_state = 6; end
                end
                6: begin
                    if (key_stop) m_state = 1;
                    else if (!key_rec && !key_play) begin
                        m_state = m_next;
                        case (m_next)
                            2: m_cmd[0] = 1;
                            3: m_cmd[1] = 1;
                            4: m_cmd[3] = 1;
                            5: m_cmd[4] = 1;
                            default: m_state = 1;
                        endcase
                    end
                end
                default: m_state = 0;
            endcase
        end
        m_wr = (m_state == 2) || (m_state == 3);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; i2c_done = 0;
        repeat (3) tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (i2c_start !== 1'b1) begin errors++; $display("FAIL reset_i2c_start: got %b want 1", i2c_start); end
        checks++; if (cmd !== 6'd0 || sram_wr !== 1'b0) begin errors++; $display("FAIL reset_pulses: cmd=%b wr=%b want 0", cmd, sram_wr); end
        checks++; if (slot_base !== 20'd0 || slot_end !== 20'd0) begin errors++; $display("FAIL reset_slot: base=%h end=%h want 0", slot_base, slot_end); end
        rst = 0;
        tick();
        checks++; if (i2c_start !== 1'b1) begin errors++; $display("FAIL i2c_start_cycle2: got %b want 1", i2c_start); end
        tick();
        checks++; if (i2c_start !== 1'b0 || state !== 3'd0) begin errors++; $display("FAIL i2c_start_drop: i2c=%b state=%0d want 0/0", i2c_start, state); end
        i2c_done = 1;
        tick();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL init_to_idle: got %0d want 1", state); end
    endtask

    task automatic test_record_slot2();
        slot = 2; rec_addr = 20'h80000; key_rec = 1;
        tick();
        checks++; if (state !== 3'd6 || cmd !== 6'd0) begin errors++; $display("FAIL rec_wrel: state=%0d cmd=%b want 6/0", state, cmd); end
        key_rec = 0;
        tick();
        checks++; if (cmd !== 6'b000001 || sram_wr !== 1'b1 || state !== 3'd2) begin errors++; $display("FAIL rec_start: cmd=%b wr=%b state=%0d want 000001/1/2", cmd, sram_wr, state); end
        tick();
        checks++; if (cmd !== 6'd0) begin errors++; $display("FAIL rec_start_once: cmd=%b want 0", cmd); end
        rec_addr = 20'h80123;
        tick();
        key_stop = 1;
        tick();
        key_stop = 0;
        checks++; if (cmd !== 6'b000100 || state !== 3'd1) begin errors++; $display("FAIL rec_stop_key: cmd=%b state=%0d want 000100/1", cmd, state); end
        checks++; if (slot_end !== 20'h80124 || slot_base !== 20'h80000) begin errors++; $display("FAIL rec_slot_end: end=%h base=%h want 80124/80000", slot_end, slot_base); end
    endtask

    task automatic test_autostop();
        slot = 0; rec_addr = 20'h00100; key_rec = 1;
        tick();
        key_rec = 0;
        tick();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL auto_enter: state=%0d want 2", state); end
        rec_addr = 20'h3FFFF; key_rec = 1;
        tick();
        key_rec = 0;
        checks++; if (cmd !== 6'b000100 || state !== 3'd1) begin errors++; $display("FAIL autostop: cmd=%b state=%0d want 000100/1", cmd, state); end
        checks++; if (slot_end !== 20'h40000) begin errors++; $display("FAIL autostop_end: got %h want 40000", slot_end); end
        rec_addr = 20'h0;
    endtask

    task automatic test_play_loop();
        slot = 2; loop_en = 0; play_addr = 20'h80000; key_play = 1;
        tick();
        key_play = 0;
        tick();
        checks++; if (cmd !== 6'b001000 || state !== 3'd4) begin errors++; $display("FAIL play_start: cmd=%b state=%0d want 001000/4", cmd, state); end
        loop_en = 1; play_addr = 20'h80124;
        tick();
        checks++; if (cmd !== 6'b100000 || state !== 3'd4) begin errors++; $display("FAIL loop_stop: cmd=%b state=%0d want 100000/4", cmd, state); end
        play_addr = 20'h80000;
        tick();
        checks++; if (cmd !== 6'b001000 || state !== 3'd4) begin errors++; $display("FAIL loop_restart: cmd=%b state=%0d want 001000/4", cmd, state); end
        tick();
        checks++; if (cmd !== 6'd0) begin errors++; $display("FAIL loop_quiet: cmd=%b want 0", cmd); end
        loop_en = 0; play_addr = 20'h80124;
        tick();
        checks++; if (cmd !== 6'b100000 || state !== 3'd1) begin errors++; $display("FAIL play_end: cmd=%b state=%0d want 100000/1", cmd, state); end
        play_addr = 20'h80000;
    endtask

    task automatic test_empty_play();
        slot = 1; key_play = 1;
        tick();
        tick();
        checks++; if (state !== 3'd1 || cmd !== 6'd0) begin errors++; $display("FAIL empty_play: state=%0d cmd=%b want 1/0", state, cmd); end
        key_play = 0;
        tick();
    endtask

    task automatic test_all_keys();
        slot = 2; play_addr = 20'h80000; key_play = 1;
        tick();
        key_play = 0;
        tick();
        key_rec = 1; key_play = 1; key_stop = 1;
        tick();
        checks++; if (cmd !== 6'b100000 || state !== 3'd1) begin errors++; $display("FAIL all_keys: cmd=%b state=%0d want 100000/1", cmd, state); end
        tick();
        checks++; if (cmd !== 6'd0) begin errors++; $display("FAIL all_keys_once: cmd=%b want 0", cmd); end
        key_rec = 0; key_play = 0; key_stop = 0;
        tick();
    endtask

    task automatic test_reset_mid_recd();
        slot = 3; rec_addr = 20'hC0010; key_rec = 1;
        tick();
        key_rec = 0;
        tick();
        tick();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL midrec_enter: state=%0d want 2", state); end
        rst = 1;
        tick();
        checks++; if (state !== 3'd0 || cmd !== 6'd0 || sram_wr !== 1'b0 || i2c_start !== 1'b1) begin errors++; $display("FAIL midrec_reset: state=%0d cmd=%b wr=%b i2c=%b want 0/0/0/1", state, cmd, sram_wr, i2c_start); end
        rst = 0; i2c_done = 1;
        tick();
        for (int k = 0; k < 4; k++) begin
            slot = 2'(k);
            tick();
            checks++; if (slot_end !== 20'(longint'(k) * LEN) || slot_base !== 20'(longint'(k) * LEN)) begin errors++; $display("FAIL slot_empty_%0d: end=%h base=%h want %h", k, slot_end, slot_base, 20'(longint'(k) * LEN)); end
            key_play = 1;
            tick();
            checks++; if (state !== 3'd1 || cmd !== 6'd0) begin errors++; $display("FAIL empty_after_reset_%0d: state=%0d cmd=%b want 1/0", k, state, cmd); end
            key_play = 0;
            tick();
        end
    endtask

    task automatic test_random();
        longint b;
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 399) == 0);
            key_rec  = ($urandom_range(0, 7) == 0);
            key_play = ($urandom_range(0, 7) == 0);
            key_stop = ($urandom_range(0, 24) == 0);
            i2c_done = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) slot = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) loop_en = ~loop_en;
            b = longint'(m_slot) * LEN;
            rec_addr  = 20'(b + (($urandom_range(0, 31) == 0) ? LEN - 1 - longint'($urandom_range(0, 1))
                                                                : longint'($urandom_range(0, 4095))));
            play_addr = 20'(b + longint'($urandom_range(0, 4300)));
            tick();
            checks++;
            if (state !== 3'(m_state) || cmd !== m_cmd || sram_wr !== m_wr || i2c_start !== m_i2c) begin
                errors++;
                $display("FAIL rand_ctrl c=%0d: state=%0d cmd=%b wr=%b i2c=%b want %0d/%b/%b/%b",
                         c, state, cmd, sram_wr, i2c_start, m_state, m_cmd, m_wr, m_i2c);
            end
            checks++;
            if (slot_base !== 20'(longint'(m_slot) * LEN) || slot_end !== 20'(m_end[m_slot])) begin
                errors++;
                $display("FAIL rand_slot c=%0d: base=%h end=%h want %h/%h",
                         c, slot_base, slot_end, 20'(longint'(m_slot) * LEN), 20'(m_end[m_slot]));
            end
            checks++;
            if (!$onehot0(cmd)) begin errors++; $display("FAIL rand_onehot c=%0d: cmd=%b", c, cmd); end
        end
        rst = 0; key_rec = 0; key_play = 0; key_stop = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_record_slot2();
        test_autostop();
        test_play_loop();
        test_empty_play();
        test_all_keys();
        test_reset_mid_recd();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
